// File: rtl/weight_update_pack.sv
// Shared types and constants for the weight/channel-estimate update controller.
//   cmd_sel_t     : target register file of a command (FFE weight or MLSD channel estimate)
//   cmd_t         : one buffered command as stored in the command FIFO
//   wupd_state_t  : controller FSM states
// The *_WIDTH/*_DEPTH/*_PRECISION constants mirror the DSP global packages so this slice
// builds on its own.
package weight_update_pack;

    localparam int unsigned CHANNEL_WIDTH      = 4;   // constant_gpack::channel_width
    localparam int unsigned ESTIMATE_DEPTH     = 4;   // mlsd_gpack::estimate_depth
    localparam int unsigned WEIGHT_PRECISION   = 10;  // ffe_gpack::weight_precision
    localparam int unsigned ESTIMATE_PRECISION = 8;   // mlsd_gpack::estimate_precision

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned CMD_DW = max_u(WEIGHT_PRECISION, ESTIMATE_PRECISION);
    // One extra bit so that out-of-range channel/tap numbers can be expressed and rejected.
    localparam int unsigned CH_W   = $clog2(CHANNEL_WIDTH) + 1;
    localparam int unsigned IDX_W  = $clog2(ESTIMATE_DEPTH) + 1;

    typedef enum logic {SEL_WEIGHT, SEL_CHAN_EST} cmd_sel_t;

    typedef struct packed {
        cmd_sel_t                  sel;
        logic                      bcast;
        logic [CH_W-1:0]           ch;
        logic [IDX_W-1:0]          idx;
        logic signed [CMD_DW-1:0]  data;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, STROBE, GAP} wupd_state_t;

endpackage

// File: rtl/dsp_debug_intf.sv
// Debug/coefficient interface between the weight update controller and the DSP datapath.
//   new_weights        : held FFE weight per channel
//   new_channel_est    : held MLSD channel estimate per channel and tap
//   update_weights     : per-channel weight update strobe
//   update_channel_est : per-channel, per-tap estimate update strobe
// Modports: weight_controller (drives everything), dsp (samples everything).
interface dsp_debug_intf
    import weight_update_pack::*;
#(
    parameter int unsigned NCH   = CHANNEL_WIDTH,
    parameter int unsigned DEPTH = ESTIMATE_DEPTH,
    parameter int unsigned WP    = WEIGHT_PRECISION,
    parameter int unsigned EP    = ESTIMATE_PRECISION
);

    logic signed [WP-1:0]      new_weights     [NCH];
    logic signed [EP-1:0]      new_channel_est [NCH][DEPTH];
    logic [NCH-1:0]            update_weights;
    logic [NCH-1:0][DEPTH-1:0] update_channel_est;

    modport weight_controller (
        output new_weights, new_channel_est, update_weights, update_channel_est
    );

    modport dsp (
        input new_weights, new_channel_est, update_weights, update_channel_est
    );

endinterface

// File: rtl/weight_update_ctrl_fifo.sv
// wupd_cmd_fifo: synchronous command FIFO of cmd_t.
//   clk, rst           : clock, synchronous active-high reset (empties the FIFO)
//   push, push_data    : write request and entry (ignored when full)
//   pop                : read request (ignored when empty)
//   head               : entry at the read pointer, straight from the storage registers
//   full, empty        : occupancy flags
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
module wupd_cmd_fifo
    import weight_update_pack::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  cmd_t push_data,
    input  logic pop,
    output cmd_t head,
    output logic full,
    output logic empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    cmd_t          mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/weight_update_ctrl.sv
// weight_update_ctrl: buffers coefficient-write commands and applies them to the DSP.
//   clk, rst        : clock, synchronous active-high reset
//   cmd_valid/ready : command handshake (ready = FIFO not full, low during reset)
//   cmd_sel/bcast/ch/idx/data : command fields
//   busy            : FIFO non-empty or FSM not idle
//   err_pulse       : one-cycle pulse when a popped command is out of range and dropped
//   dbg             : held data registers and update strobes towards the DSP
// Each accepted command writes its data and raises the matching strobe(s) for UPD_LEN cycles,
// then waits GAP_LEN idle cycles before the next pop, so the DSP always samples stable data.
module weight_update_ctrl
    import weight_update_pack::*;
#(
    parameter int unsigned NCH        = CHANNEL_WIDTH,
    parameter int unsigned DEPTH      = ESTIMATE_DEPTH,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned UPD_LEN    = 2,
    parameter int unsigned GAP_LEN    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  cmd_sel_t                 cmd_sel,
    input  logic                     cmd_bcast,
    input  logic [CH_W-1:0]          cmd_ch,
    input  logic [IDX_W-1:0]         cmd_idx,
    input  logic signed [CMD_DW-1:0] cmd_data,
    output logic                     busy,
    output logic                     err_pulse,
    dsp_debug_intf.weight_controller dbg
);

    localparam int unsigned CNT_MAX = max_u(UPD_LEN, GAP_LEN);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    wupd_state_t      state_q;
    logic [CNT_W-1:0] cnt_q;
    cmd_t             push_cmd, head;
    logic             fifo_full, fifo_empty, pop;
    logic             ch_bad, idx_bad;

    assign cmd_ready = !rst && !fifo_full;
    assign push_cmd  = '{sel: cmd_sel, bcast: cmd_bcast, ch: cmd_ch, idx: cmd_idx,
                         data: cmd_data};
    assign pop       = (state_q == IDLE) && !fifo_empty;
    assign busy      = (state_q != IDLE) || !fifo_empty;

    assign ch_bad  = !head.bcast && (32'(head.ch) >= NCH);
    assign idx_bad = (head.sel == SEL_CHAN_EST) && (32'(head.idx) >= DEPTH);

    wupd_cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid && cmd_ready),
        .push_data (push_cmd),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q                <= IDLE;
            cnt_q                  <= '0;
            err_pulse              <= 1'b0;
            dbg.update_weights     <= '0;
            dbg.update_channel_est <= '0;
            for (int c = 0; c < NCH; c++) begin
                dbg.new_weights[c] <= '0;
                for (int i = 0; i < DEPTH; i++) dbg.new_channel_est[c][i] <= '0;
            end
        end else begin
            err_pulse <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        if (ch_bad || idx_bad) begin
                            // Dropped: no data or strobe change, try the next entry.
                            err_pulse <= 1'b1;
                        end else begin
                            for (int c = 0; c < NCH; c++) begin
                                if (head.bcast || head.ch == CH_W'(c)) begin
                                    if (head.sel == SEL_WEIGHT) begin
                                        dbg.new_weights[c]    <= head.data[WEIGHT_PRECISION-1:0];
                                        dbg.update_weights[c] <= 1'b1;
                                    end else begin
                                        for (int i = 0; i < DEPTH; i++) begin
                                            if (head.idx == IDX_W'(i)) begin
                                                dbg.new_channel_est[c][i] <=
                                                    head.data[ESTIMATE_PRECISION-1:0];
                                                dbg.update_channel_est[c][i] <= 1'b1;
                                            end
                                        end
                                    end
                                end
                            end
                            cnt_q   <= CNT_W'(UPD_LEN - 1);
                            state_q <= STROBE;
                        end
                    end
                end
                STROBE: begin
                    if (cnt_q == '0) begin
                        dbg.update_weights     <= '0;
                        dbg.update_channel_est <= '0;
                        if (GAP_LEN == 0) begin
                            state_q <= IDLE;
                        end else begin
                            cnt_q   <= CNT_W'(GAP_LEN - 1);
                            state_q <= GAP;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_q == '0) state_q <= IDLE;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_update_ctrl.sv
// Scoreboard bench for weight_update_ctrl: each pushed command queues its expected outcome
// (error or strobe), and a negedge monitor pops and checks it when the DUT reacts, while
// comparing the held data registers against a reference model every cycle.
module tb_weight_update_ctrl;
    import weight_update_pack::*;

    localparam int unsigned NCH     = CHANNEL_WIDTH;
    localparam int unsigned DEPTH   = ESTIMATE_DEPTH;
    localparam int unsigned UPD_LEN = 2;
    localparam int unsigned GAP_LEN = 1;
    localparam int          SPACING = 1 + UPD_LEN + GAP_LEN;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     cmd_valid = 1'b0;
    cmd_sel_t                 cmd_sel = SEL_WEIGHT;
    logic                     cmd_bcast = 1'b0;
    logic [CH_W-1:0]          cmd_ch = '0;
    logic [IDX_W-1:0]         cmd_idx = '0;
    logic signed [CMD_DW-1:0] cmd_data = '0;
    logic                     cmd_ready, busy, err_pulse;

    dsp_debug_intf dbg_if ();

    weight_update_ctrl #(
        .NCH        (NCH),
        .DEPTH      (DEPTH),
        .FIFO_DEPTH (4),
        .UPD_LEN    (UPD_LEN),
        .GAP_LEN    (GAP_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_sel   (cmd_sel),
        .cmd_bcast (cmd_bcast),
        .cmd_ch    (cmd_ch),
        .cmd_idx   (cmd_idx),
        .cmd_data  (cmd_data),
        .busy      (busy),
        .err_pulse (err_pulse),
        .dbg       (dbg_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit       err;
        cmd_sel_t sel;
        bit       bcast;
        int       ch;
        int       idx;
        int       data;
        int       push_cyc;
        bit       chk_lat;
        bit       chk_space;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   mw [NCH];
    int   mce [NCH][DEPTH];
    int   n_checks = 0, n_errs = 0;
    int   err_seen = 0, starts = 0, slen = 0, last_start = 0;
    bit   prev_any = 1'b0, saw_full = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int trunc_w(input int v);
        logic signed [WEIGHT_PRECISION-1:0] t;
        t = v[WEIGHT_PRECISION-1:0];
        return int'(t);
    endfunction

    function automatic int trunc_e(input int v);
        logic signed [ESTIMATE_PRECISION-1:0] t;
        t = v[ESTIMATE_PRECISION-1:0];
        return int'(t);
    endfunction

    function automatic int data_mismatches();
        int n = 0;
        for (int c = 0; c < NCH; c++) begin
            if (int'(dbg_if.new_weights[c]) != mw[c]) n++;
            for (int i = 0; i < DEPTH; i++)
                if (int'(dbg_if.new_channel_est[c][i]) != mce[c][i]) n++;
        end
        return n;
    endfunction

    // Monitor: samples at negedge, drivers change inputs at posedge+2.
    always @(negedge clk) begin
        logic [NCH-1:0]            exp_w;
        logic [NCH-1:0][DEPTH-1:0] exp_ce;
        exp_t                      e;
        bit                        any;
        if (rst) begin
            prev_any = 1'b0;
            slen     = 0;
        end else begin
            any = (dbg_if.update_weights != '0) || (dbg_if.update_channel_est != '0);
            if (err_pulse) begin
                err_seen++;
                if (sb.size() == 0) begin
                    check_eq("err_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check_eq("err_expected", 1, e.err);
                end
                check_eq("err_no_strobe", any, 0);
            end
            if (any && !prev_any) begin
                starts++;
                if (sb.size() == 0) begin
                    check_eq("strobe_unexpected", 1, 0);
                    cur.err = 1'b1;
                end else begin
                    cur = sb.pop_front();
                    check_eq("strobe_for_valid_cmd", cur.err, 0);
                    // First strobe is seen after the edge following the push edge.
                    if (cur.chk_lat) check_eq("latency", cyc - cur.push_cyc, 1);
                    if (cur.chk_space) check_eq("spacing", cyc - last_start, SPACING);
                    if (!cur.err) begin
                        for (int c = 0; c < NCH; c++) begin
                            if (cur.bcast || cur.ch == c) begin
                                if (cur.sel == SEL_WEIGHT) mw[c] = trunc_w(cur.data);
                                else mce[c][cur.idx] = trunc_e(cur.data);
                            end
                        end
                    end
                end
                last_start = cyc;
            end
            if (any) begin
                exp_w  = '0;
                exp_ce = '0;
                for (int c = 0; c < NCH; c++) begin
                    if (!cur.err && (cur.bcast || cur.ch == c)) begin
                        if (cur.sel == SEL_WEIGHT) exp_w[c] = 1'b1;
                        else exp_ce[c][cur.idx] = 1'b1;
                    end
                end
                check_eq("upd_weights_mask", dbg_if.update_weights, exp_w);
                check_eq("upd_chan_est_mask", dbg_if.update_channel_est, exp_ce);
                slen++;
            end else if (prev_any) begin
                check_eq("strobe_len", slen, UPD_LEN);
                slen = 0;
            end
            check_eq("data_vs_model", data_mismatches(), 0);
            prev_any = any;
        end
    end

    task automatic push_cmd(input cmd_sel_t sel, input bit bcast, input int ch, input int idx,
                            input int data, input bit chk_lat, input bit chk_space);
        exp_t e;
        int   waited = 0;
        cmd_valid = 1'b1;
        cmd_sel   = sel;
        cmd_bcast = bcast;
        cmd_ch    = CH_W'(ch);
        cmd_idx   = IDX_W'(idx);
        cmd_data  = CMD_DW'(data);
        while (!cmd_ready && waited < 50) begin
            saw_full = 1'b1;
            @(posedge clk);
            #2;
            waited++;
        end
        if (!cmd_ready) begin
            check_eq("push_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        e.err       = (!bcast && ch >= int'(NCH)) || (sel == SEL_CHAN_EST && idx >= int'(DEPTH));
        e.sel       = sel;
        e.bcast     = bcast;
        e.ch        = ch;
        e.idx       = idx;
        e.data      = data;
        e.push_cyc  = cyc + 1;
        e.chk_lat   = chk_lat;
        e.chk_space = chk_space;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 200 && (busy || sb.size() != 0); i++) begin
            @(posedge clk);
            #2;
        end
        check_eq({tag, "_busy_low"}, busy, 0);
        check_eq({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    task automatic clear_model();
        for (int c = 0; c < NCH; c++) begin
            mw[c] = 0;
            for (int i = 0; i < DEPTH; i++) mce[c][i] = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int starts0, err0;
        clear_model();
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_cmd_ready", cmd_ready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_err", err_pulse, 0);
        check_eq("rst_upd_w", dbg_if.update_weights, 0);
        check_eq("rst_upd_ce", dbg_if.update_channel_est, 0);
        check_eq("rst_data", data_mismatches(), 0);
        rst = 1'b0;
        @(posedge clk);
        #2;
        check_eq("ready_after_rst", cmd_ready, 1);

        // 1: single weight write with latency check
        push_cmd(SEL_WEIGHT, 0, 3, 0, -5, 1, 0);
        cmd_valid = 1'b0;
        check_eq("t1_busy", busy, 1);
        wait_done("t1");
        check_eq("t1_w3", int'(dbg_if.new_weights[3]), -5);

        // 2: broadcast channel-estimate write to tap 1
        push_cmd(SEL_CHAN_EST, 1, 0, 1, 17, 1, 0);
        cmd_valid = 1'b0;
        wait_done("t2");
        check_eq("t2_ce21", int'(dbg_if.new_channel_est[2][1]), 17);
        check_eq("t2_ce20", int'(dbg_if.new_channel_est[2][0]), 0);

        // 3: six back-to-back commands overflow a 4-deep FIFO
        saw_full = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) push_cmd(SEL_WEIGHT, 0, k % 4, 0, k * 10 - 7, k == 0, k > 0);
            else push_cmd(SEL_CHAN_EST, 0, k % 4, (k + 1) % 4, -(k * 3), 0, 1);
        end
        cmd_valid = 1'b0;
        check_eq("t3_saw_full", saw_full, 1);
        wait_done("t3");

        // 4: two out-of-range commands then a valid one
        err0 = err_seen;
        push_cmd(SEL_CHAN_EST, 0, NCH, 0, 9, 0, 0);
        push_cmd(SEL_CHAN_EST, 0, 0, DEPTH, 9, 0, 0);
        push_cmd(SEL_CHAN_EST, 0, 0, 2, -3, 0, 0);
        cmd_valid = 1'b0;
        wait_done("t4");
        check_eq("t4_err_count", err_seen - err0, 2);
        check_eq("t4_ce02", int'(dbg_if.new_channel_est[0][2]), -3);

        // 5: reset during a strobe with two commands still queued
        push_cmd(SEL_WEIGHT, 0, 1, 0, 55, 1, 0);
        push_cmd(SEL_WEIGHT, 0, 1, 0, 66, 0, 0);
        push_cmd(SEL_WEIGHT, 0, 1, 0, 77, 0, 0);
        cmd_valid = 1'b0;
        check_eq("t5_strobe_active", dbg_if.update_weights[1], 1);
        rst = 1'b1;
        sb.delete();
        clear_model();
        starts0 = starts;
        @(posedge clk);
        #2;
        check_eq("t5_upd_w", dbg_if.update_weights, 0);
        check_eq("t5_upd_ce", dbg_if.update_channel_est, 0);
        check_eq("t5_data", data_mismatches(), 0);
        check_eq("t5_busy", busy, 0);
        check_eq("t5_ready_in_rst", cmd_ready, 0);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        check_eq("t5_no_issue", starts, starts0);
        check_eq("t5_busy_after", busy, 0);

        // 6: overwrite of one weight; model check covers stability every cycle
        push_cmd(SEL_WEIGHT, 0, 2, 0, 100, 1, 0);
        push_cmd(SEL_WEIGHT, 0, 2, 0, -1, 0, 1);
        cmd_valid = 1'b0;
        wait_done("t6");
        check_eq("t6_w2", int'(dbg_if.new_weights[2]), -1);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
